// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered LEGv8 immediate generator for the ID stage.
// Decodes D, CB, B, I and IW (MOVZ) immediates, reports the decoded format,
// and buffers results in a main + skid register pair so back-pressure from
// ID/EX never drops an instruction.
// Optional build macro: BRANCH_SHIFT_EN (CB/B immediates become byte offsets).
module imm_gen_pipe #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_imm,
  output logic [2:0]   out_fmt
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_D    = 3'd1;
  localparam logic [2:0] FMT_CB   = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_I    = 3'd4;
  localparam logic [2:0] FMT_IW   = 3'd5;

  // Decode one instruction word into {imm64, fmt}; first matching opcode wins.
  function automatic logic [66:0] decode(input logic [31:0] ins);
    logic signed [63:0] imm;
    logic [2:0]         fmt;
    imm = '0;
    fmt = FMT_NONE;
    if (ins[31:21] == 11'b11111000010 || ins[31:21] == 11'b11111000000) begin
      imm = 64'($signed(ins[20:12]));
      fmt = FMT_D;
    end else if (ins[31:24] == 8'b10110100 || ins[31:24] == 8'b10110101) begin
      imm = 64'($signed(ins[23:5]));
`ifdef BRANCH_SHIFT_EN
      imm = imm <<< 2;
`endif
      fmt = FMT_CB;
    end else if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
      imm = 64'($signed(ins[25:0]));
`ifdef BRANCH_SHIFT_EN
      imm = imm <<< 2;
`endif
      fmt = FMT_B;
    end else if (ins[31:22] == 10'b1001000100 || ins[31:22] == 10'b1101000100) begin
      imm = $signed({52'd0, ins[21:10]});
      fmt = FMT_I;
    end else if (ins[31:23] == 9'b110100101) begin
      // hw field selects a 16-bit lane; bits shifted past N are dropped later
      imm = $signed({48'd0, ins[20:5]} << {ins[22:21], 4'b0000});
      fmt = FMT_IW;
    end
    return {imm, fmt};
  endfunction

  logic [66:0]  dec;
  logic [N-1:0] dec_imm;
  logic [2:0]   dec_fmt;

  logic         main_vld_q, main_vld_d;
  logic [N-1:0] main_imm_q, main_imm_d;
  logic [2:0]   main_fmt_q, main_fmt_d;
  logic         skid_vld_q, skid_vld_d;
  logic [N-1:0] skid_imm_q, skid_imm_d;
  logic [2:0]   skid_fmt_q, skid_fmt_d;

  logic accept;
  logic drain;

  // Combinational decode of the presented instruction, truncated to N bits.
  always_comb begin
    dec     = decode(instr);
    dec_imm = dec[N+2:3];
    dec_fmt = dec[2:0];
  end

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_imm   = main_imm_q;
  assign out_fmt   = main_fmt_q;
  assign accept    = in_valid && in_ready;
  assign drain     = main_vld_q && out_ready;

  // Next-state for main/skid: flush wins, skid refills main first to keep order.
  always_comb begin
    main_vld_d = main_vld_q;
    main_imm_d = main_imm_q;
    main_fmt_d = main_fmt_q;
    skid_vld_d = skid_vld_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_imm_d = skid_imm_q;
        main_fmt_d = skid_fmt_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_vld_d = 1'b1;
        main_imm_d = dec_imm;
        main_fmt_d = dec_fmt;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_imm_d = dec_imm;
      skid_fmt_d = dec_fmt;
    end
  end

  // State registers; reset clears both entries and zeroes the visible outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld_q <= 1'b0;
      main_imm_q <= '0;
      main_fmt_q <= FMT_NONE;
      skid_vld_q <= 1'b0;
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
    end else begin
      main_vld_q <= main_vld_d;
      main_imm_q <= main_imm_d;
      main_fmt_q <= main_fmt_d;
      skid_vld_q <= skid_vld_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe (N=64): directed steps with a scoreboard queue.
module tb_imm_gen_pipe;

  localparam int N = 64;

`ifdef BRANCH_SHIFT_EN
  localparam logic [63:0] E_CBZ = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] E_B   = 64'h0000_0000_0000_0004;
  localparam logic [63:0] E_BL  = 64'hFFFF_FFFF_FFFF_FFFC;
`else
  localparam logic [63:0] E_CBZ = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] E_B   = 64'h0000_0000_0000_0001;
  localparam logic [63:0] E_BL  = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
  localparam logic [63:0] E_LDUR = 64'hFFFF_FFFF_FFFF_FFF0;
  localparam logic [63:0] E_ADDI = 64'h0000_0000_0000_0FFF;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  instr;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_imm;
  logic [2:0]   out_fmt;

  int checks = 0;
  int errors = 0;

  logic [66:0] sb_q[$];
  logic [63:0] pend_imm;
  logic [2:0]  pend_fmt;

  imm_gen_pipe #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Score the output/input transfers that happen at the coming edge, then advance.
  task automatic tick();
    logic [66:0] e;
    if (out_valid && out_ready && !reset) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 64'(out_fmt), 64'h7);
      end else begin
        e = sb_q.pop_front();
        check("out_imm", out_imm, e[66:3]);
        check("out_fmt", 64'(out_fmt), 64'(e[2:0]));
      end
    end
    if (in_valid && in_ready && !flush && !reset)
      sb_q.push_back({pend_imm, pend_fmt});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [63:0] ei, input logic [2:0] ef);
    int n;
    n        = 0;
    instr    = w;
    in_valid = 1'b1;
    pend_imm = ei;
    pend_fmt = ef;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (sb_q.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    pend_imm  = '0;
    pend_fmt  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_imm",   out_imm,        64'd0);
    check("rst_out_fmt",   64'(out_fmt),   64'd0);

    // Single LDUR, one-cycle latency
    out_ready = 1'b1;
    send(32'hF85F_0000, E_LDUR, 3'd1);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_imm",   out_imm,        E_LDUR);
    check("lat_out_fmt",   64'(out_fmt),   64'd1);
    drain();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Streaming through every format
    send(32'hB4FF_FFE0, E_CBZ, 3'd2);
    send(32'h1400_0001, E_B, 3'd3);
    send(32'h97FF_FFFF, E_BL, 3'd3);
    send(32'h913F_FC00, E_ADDI, 3'd4);
    send(32'hD100_0400, 64'h1, 3'd4);
    send(32'hD2D5_79A0, 64'h0000_ABCD_0000_0000, 3'd5);
    send(32'hD2E0_0020, 64'h0001_0000_0000_0000, 3'd5);
    send(32'h0000_0000, 64'h0, 3'd0);
    send(32'hF800_0000, 64'h0, 3'd1);
    drain();

    // Back-pressure: LDUR then ADDI while stalled
    out_ready = 1'b0;
    send(32'hF85F_0000, E_LDUR, 3'd1);
    send(32'h913F_FC00, E_ADDI, 3'd4);
    check("bp_in_ready",  64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_hold_imm",  out_imm, E_LDUR);
    tick();
    tick();
    check("bp_hold2_imm", out_imm, E_LDUR);
    check("bp_hold2_fmt", 64'(out_fmt), 64'd1);
    check("bp_hold2_rdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_rdy_after_drain", 64'(in_ready), 64'd1);
    check("bp_second_valid",    64'(out_valid), 64'd1);
    tick();
    check("bp_empty_valid", 64'(out_valid), 64'd0);
    check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Flush with both entries full and a concurrent input
    out_ready = 1'b0;
    send(32'h1400_0001, E_B, 3'd3);
    send(32'hB4FF_FFE0, E_CBZ, 3'd2);
    check("fl_full_rdy", 64'(in_ready), 64'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'hD2D5_79A0;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fl_stays_empty", 64'(out_valid), 64'd0);
      tick();
    end

    // Flush with only main full: concurrent input is dropped too
    out_ready = 1'b0;
    send(32'h913F_FC00, E_ADDI, 3'd4);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'hF85F_0000;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    check("fl2_out_valid", 64'(out_valid), 64'd0);
    check("fl2_in_ready",  64'(in_ready),  64'd1);

    // Recovery after flush
    send(32'h913F_FC00, E_ADDI, 3'd4);
    drain();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(32'hF85F_0000, E_LDUR, 3'd1);
    send(32'h913F_FC00, E_ADDI, 3'd4);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd1);
    check("arst_out_imm",   out_imm,        64'd0);
    check("arst_out_fmt",   64'(out_fmt),   64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    send(32'hD2D5_79A0, 64'h0000_ABCD_0000_0000, 3'd5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
